// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one clock-enabled, presettable register between N_REQ requesters.
// Optional preset command built when REG_ARB_PRESET_CMD_EN is defined (adds clr_req/clr_ack).
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                     C,
  input  logic                     R,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
`ifdef REG_ARB_PRESET_CMD_EN
  input  logic                     clr_req,
  output logic                     clr_ack,
`endif
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     reg_ce,
  output logic [WIDTH-1:0]         reg_d,
  output logic                     reg_pre,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int IW = $clog2(N_REQ);

  // Handshake: req[i] is a level held until ack[i]; ack[i] is a one-cycle pulse
  // and the requester drops req[i] the cycle after seeing it. A req still high
  // when the arbiter is back in IDLE is a fresh request.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
`ifdef REG_ARB_PRESET_CMD_EN
    , PRESET = 2'd3
`endif
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0] r_ack, w_ack_nxt;
  logic [IW-1:0]   r_grant_id, w_grant_id_nxt;
  logic            r_ce, w_ce_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  logic            r_busy, w_busy_nxt;
  logic            w_any;
  logic [IW-1:0]   w_win;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // Walk offsets from the far end so the lowest offset from ptr is the last writer.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = wrap_idx(r_ptr, k);
      end
    end
  end

`ifdef REG_ARB_PRESET_CMD_EN
  logic r_pre, w_pre_nxt;
  logic r_clr_ack, w_clr_ack_nxt;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_ack_nxt      = r_ack;
    w_grant_id_nxt = r_grant_id;
    w_ce_nxt       = r_ce;
    w_d_nxt        = r_d;
    w_busy_nxt     = r_busy;
`ifdef REG_ARB_PRESET_CMD_EN
    w_pre_nxt      = r_pre;
    w_clr_ack_nxt  = r_clr_ack;
`endif
    case (r_state)
      IDLE: begin
        w_ce_nxt  = 1'b0;
        w_ack_nxt = '0;
`ifdef REG_ARB_PRESET_CMD_EN
        if (clr_req) begin
          w_pre_nxt     = 1'b1;
          w_clr_ack_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = PRESET;
        end else
`endif
        if (w_any) begin
          w_grant_id_nxt   = w_win;
          w_d_nxt          = data[w_win*WIDTH +: WIDTH];
          w_ce_nxt         = 1'b1;
          w_ack_nxt[w_win] = 1'b1;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        w_ce_nxt    = 1'b0;
        w_ack_nxt   = '0;
        w_ptr_nxt   = (r_grant_id == IW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        w_state_nxt = GAP;
      end
      GAP: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
`ifdef REG_ARB_PRESET_CMD_EN
      PRESET: begin
        w_pre_nxt     = 1'b0;
        w_clr_ack_nxt = 1'b0;
        w_state_nxt   = GAP;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_ack      <= '0;
      r_grant_id <= '0;
      r_ce       <= 1'b0;
      r_d        <= '0;
      r_busy     <= 1'b0;
`ifdef REG_ARB_PRESET_CMD_EN
      r_pre      <= 1'b0;
      r_clr_ack  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_ack      <= w_ack_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_ce       <= w_ce_nxt;
      r_d        <= w_d_nxt;
      r_busy     <= w_busy_nxt;
`ifdef REG_ARB_PRESET_CMD_EN
      r_pre      <= w_pre_nxt;
      r_clr_ack  <= w_clr_ack_nxt;
`endif
    end
  end

  assign ack       = r_ack;
  assign grant_id  = r_grant_id;
  assign reg_ce    = r_ce;
  assign reg_d     = r_d;
  assign busy      = r_busy;
  assign dbg_state = r_state;
`ifdef REG_ARB_PRESET_CMD_EN
  assign reg_pre   = r_pre;
  assign clr_ack   = r_clr_ack;
`else
  assign reg_pre   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: transaction-level model checked every cycle, plus directed literal checks.
// Preset-command scenarios are included when REG_ARB_PRESET_CMD_EN is defined.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic             C = 1'b0;
  logic             R = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   data = '0;
  logic [N-1:0]     ack;
  logic [1:0]       grant_id;
  logic             reg_ce;
  logic [W-1:0]     reg_d;
  logic             reg_pre;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef REG_ARB_PRESET_CMD_EN
  logic             clr_req = 1'b0;
  logic             clr_ack;
`endif

  always #5 C = ~C;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .C(C), .R(R), .req(req), .data(data),
`ifdef REG_ARB_PRESET_CMD_EN
    .clr_req(clr_req), .clr_ack(clr_ack),
`endif
    .ack(ack), .grant_id(grant_id), .reg_ce(reg_ce), .reg_d(reg_d),
    .reg_pre(reg_pre), .busy(busy), .dbg_state(dbg_state)
  );

  // The shared register the arbiter drives: clock enable plus asynchronous preset.
  logic [W-1:0] q;
  always @(posedge C or posedge reg_pre) begin
    if (reg_pre) q <= '1;
    else if (reg_ce) q <= reg_d;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] ack_log[$];
  int           cyc_log[$];
  int           cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_left counts edges until the arbiter can grant again; a write occupies
  // three edges (grant, issue, gap) and a preset likewise.
  int           m_ptr = 0;
  int           m_last = 0;
  int           m_left = 0;
  int           m_w;
  bit           m_valid = 0;
  logic [N-1:0] e_ack = '0;
  int           e_gid = 0;
  logic         e_ce = 0;
  logic [W-1:0] e_d = '0;
  logic         e_busy = 0;
  logic         e_pre = 0;
  logic         e_clr = 0;

  always @(posedge C) begin
    if (R) begin
      e_ack = '0; e_gid = 0; e_ce = 0; e_d = '0; e_busy = 0; e_pre = 0; e_clr = 0;
      m_ptr = 0; m_left = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_left == 0) begin
        e_ce = 0; e_ack = '0;
        m_w = -1;
        for (int k = 0; k < N; k++)
          if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
`ifdef REG_ARB_PRESET_CMD_EN
        if (clr_req) begin
          e_pre = 1; e_clr = 1; e_busy = 1; m_left = 3; m_w = -1;
        end
`endif
        if (m_w >= 0) begin
          e_gid = m_w; e_ack[m_w] = 1'b1; e_d = data[m_w*W +: W];
          e_ce = 1; e_busy = 1; m_last = m_w; m_left = 2;
        end
      end else if (m_left == 3) begin
        e_pre = 0; e_clr = 0; m_left = 1;
      end else if (m_left == 2) begin
        e_ce = 0; e_ack = '0; m_ptr = (m_last + 1) % N; m_left = 1;
      end else begin
        e_busy = 0; m_left = 0;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge C) begin
    if (m_valid) begin
      check("ack", ack, e_ack);
      check("grant_id", grant_id, e_gid);
      check("reg_ce", reg_ce, e_ce);
      check("reg_d", reg_d, e_d);
      check("busy", busy, e_busy);
      check("reg_pre", reg_pre, e_pre);
`ifdef REG_ARB_PRESET_CMD_EN
      check("clr_ack", clr_ack, e_clr);
`endif
      if (ack != '0) begin
        ack_log.push_back(ack);
        cyc_log.push_back(cyc);
      end
    end
    cyc++;
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(negedge C);
  endtask

  int base;

  initial begin
    // Reset held two cycles with every request up.
    R = 1'b1; req = 4'b1111; data = 16'h4321;
    step(2);
    check("rst_ack", ack, 4'b0000);
    check("rst_ce", reg_ce, 1'b0);
    check("rst_d", reg_d, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_gid", grant_id, 2'd0);
    R = 1'b0; req = '0;
    step(1);

    // Single request from requester 2.
    data = 16'h0A00; req = 4'b0100;
    step(1);
    check("single_ack", ack, 4'b0100);
    check("single_ce", reg_ce, 1'b1);
    check("single_d", reg_d, 4'hA);
    check("single_gid", grant_id, 2'd2);
    req = '0;
    step(1);
    check("single_q", q, 4'hA);
    check("single_busy_gap", busy, 1'b1);
    step(1);
    check("single_busy_low", busy, 1'b0);

    // Round robin from ptr=0 with all requests held.
    R = 1'b1; step(1); R = 1'b0;
    ack_log.delete(); cyc_log.delete();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    data = 16'h4321; req = 4'b1111;
    step(12);
    req = '0;
    check("rr_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      check("rr_order", ack_log[i], exp_q[i]);
      if (i > 0) check("rr_spacing", cyc_log[i] - cyc_log[i-1], 3);
    end
    check("rr_last_q", q, 4'h4);

    // Pointer skip: move ptr to 1, then 3 beats 0 when both request.
    req = 4'b0001; step(1); req = '0; step(2);
    data = 16'h7008; req = 4'b1001;
    step(1);
    check("skip_ack3", ack, 4'b1000);
    check("skip_d3", reg_d, 4'h7);
    req = 4'b0001;
    step(3);
    check("skip_ack0", ack, 4'b0001);
    check("skip_gid0", grant_id, 2'd0);
    req = '0; step(2);

    // Request raised while busy and withdrawn before IDLE is never acknowledged.
    base = ack_log.size();
    data = 16'h0300; req = 4'b0100;
    step(1); req = 4'b1000;
    step(1); req = 4'b0000;
    step(2);
    check("drop_acks", ack_log.size() - base, 1);
    check("drop_busy", busy, 1'b0);

    // Reset during ISSUE: register still loads, controller returns to ptr=0.
    data = 16'h0050; req = 4'b0010;
    step(1);
    check("mid_ce", reg_ce, 1'b1);
    check("mid_d", reg_d, 4'h5);
    R = 1'b1; req = '0;
    step(1);
    check("mid_q", q, 4'h5);
    check("mid_ack", ack, 4'b0000);
    check("mid_ce_off", reg_ce, 1'b0);
    check("mid_d_clr", reg_d, 4'h0);
    check("mid_busy", busy, 1'b0);
    R = 1'b0; data = 16'h4321; req = 4'b1111;
    step(1);
    check("mid_ptr0", ack, 4'b0001);
    req = '0; step(2);

`ifdef REG_ARB_PRESET_CMD_EN
    // Preset wins over a pending write, then the write follows.
    clr_req = 1'b1; data = 16'h00C0; req = 4'b0010;
    step(1);
    check("pre_pulse", reg_pre, 1'b1);
    check("pre_clr_ack", clr_ack, 1'b1);
    check("pre_no_ack", ack, 4'b0000);
    check("pre_q", q, 4'hF);
    clr_req = 1'b0;
    step(1);
    check("pre_low", reg_pre, 1'b0);
    check("pre_gid_kept", grant_id, 2'd0);
    step(2);
    check("pre_then_ack", ack, 4'b0010);
    req = '0;
    step(1);
    check("pre_then_q", q, 4'hC);
    step(1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1);
  end

endmodule
